// File: rtl/conv_weight_stream_pkg.sv
// Shared definitions for the 3x3 conv weight streamer: FSM encodings,
// buffer depth, and the total word count of one weight pass.
package conv_weight_stream_pkg;

    localparam int FIFO_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int total_words(input int ch_out, input int ch_in, input int kernel);
        return ch_out * ch_in * kernel * kernel;
    endfunction

endpackage

// File: rtl/conv_weight_skid_fifo.sv
// Two-entry FIFO, head presented combinationally (zero read latency).
// Caller guarantees no push when full and no pop when empty.
module conv_weight_skid_fifo
    import conv_weight_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entries [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = entries[rd_ptr];

endmodule

// File: rtl/conv_weight_stream_3x3.sv
// Streams a layer's 3x3 kernels from a 1-cycle-latency weight memory at 1 word/cycle;
// first word 2 cycles after start, reads throttled by a 2-entry credit. Optional WEIGHT_LAST_FLAG_EN.
module conv_weight_stream_3x3
    import conv_weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int KERNEL          = 3,
    parameter int ADDR_WIDTH      = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  ready_in,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  busy,
    output logic                  done
`ifdef WEIGHT_LAST_FLAG_EN
    ,
    output logic                  weight_last
`endif
);

    localparam int N = total_words(CHANNEL_NUM_OUT, CHANNEL_NUM_IN, KERNEL);

`ifdef WEIGHT_LAST_FLAG_EN
    localparam int FW     = DATA_WIDTH + 1;
    localparam int PER_CO = CHANNEL_NUM_IN * KERNEL * KERNEL;
`else
    localparam int FW     = DATA_WIDTH;
`endif

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  inflight;
    logic [1:0]            count;
    logic [FW-1:0]         push_data;
    logic [FW-1:0]         head_data;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  last_addr;
    logic                  drain_empty;

    // Credit counts words already buffered plus the read whose data lands next edge.
    assign pop         = valid_weight_out & ready_in;
    assign occupancy   = {1'b0, count} + {2'b00, inflight};
    assign mem_rd_en   = (state == ST_RUN) && ((occupancy - {2'b00, pop}) < 3'(FIFO_DEPTH));
    assign mem_addr    = addr;
    assign last_addr   = (addr == ADDR_WIDTH'(N - 1));
    assign drain_empty = !inflight && ((count == 2'd0) || (count == 2'd1 && pop));

`ifdef WEIGHT_LAST_FLAG_EN
    logic [ADDR_WIDTH-1:0] co_tap;
    logic                  co_tap_last;
    logic                  inflight_last;

    assign co_tap_last = (co_tap == ADDR_WIDTH'(PER_CO - 1));
    assign push_data   = {inflight_last, mem_data};
    assign weight_last = valid_weight_out & head_data[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            co_tap        <= '0;
            inflight_last <= 1'b0;
        end else begin
            inflight_last <= mem_rd_en & co_tap_last;
            if (state == ST_IDLE) begin
                co_tap <= '0;
            end else if (mem_rd_en) begin
                co_tap <= co_tap_last ? '0 : co_tap + 1'b1;
            end
        end
    end
`else
    assign push_data = mem_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        addr  <= '0;
                    end
                end
                ST_RUN: begin
                    if (mem_rd_en) begin
                        if (last_addr) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                // Leave as the final word is accepted so done lands one cycle later.
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    addr  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    conv_weight_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign valid_weight_out = (count != 2'd0);
    assign weight_out       = valid_weight_out ? head_data[DATA_WIDTH-1:0] : '0;
    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);

endmodule

// File: tb/tb_conv_weight_stream_3x3.sv
// Scoreboard bench for conv_weight_stream_3x3 with a 2x2x3x3 kernel set (36 words, word i = i).
module tb_conv_weight_stream_3x3;

    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int WORDS = 36;
    localparam int PERCO = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          ready_in;
    logic          valid_weight_out;
    logic [DW-1:0] weight_out;
    logic          busy;
    logic          done;
`ifdef WEIGHT_LAST_FLAG_EN
    logic          weight_last;
`endif

    int unsigned exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    conv_weight_stream_3x3 #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM_IN  (2),
        .CHANNEL_NUM_OUT (2),
        .KERNEL          (3),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .ready_in         (ready_in),
        .valid_weight_out (valid_weight_out),
        .weight_out       (weight_out),
        .busy             (busy),
        .done             (done)
`ifdef WEIGHT_LAST_FLAG_EN
        ,
        .weight_last      (weight_last)
`endif
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= DW'(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: ready_in = 1'b1;
            1: ready_in = ~ready_in;
            default: ;
        endcase
    endtask

    task automatic push_pass();
        for (int i = 0; i < WORDS; i++) exp_q.push_back(i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 600) begin
            step();
            n++;
        end
        check("pass_finished_in_time", n < 600, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: pops expected words on every transfer, tracks done timing and read credit.
    initial begin
        int          words = 0;
        int          occ = 0;
        bit          exp_done = 0;
        bit          after_done = 0;
        bit          nxt_done;
        bit          pop;
        int unsigned e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                words = 0; occ = 0; exp_done = 0; after_done = 0;
            end else begin
                check("done_pulse", done, exp_done);
                if (after_done) check("busy_after_done", busy, 0);
                after_done = exp_done;
                if (words > 0) check("no_gap_in_stream", valid_weight_out, 1);
                pop = valid_weight_out && ready_in;
                if (mem_rd_en) check("read_credit", (occ - int'(pop)) < 2, 1);
                occ = occ + int'(mem_rd_en) - int'(pop);
                nxt_done = 0;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", weight_out, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("weight_data", weight_out, e);
`ifdef WEIGHT_LAST_FLAG_EN
                        check("weight_last", weight_last, (e % PERCO) == PERCO - 1);
`endif
                        words++;
                        if (words == WORDS) begin
                            words = 0;
                            nxt_done = 1;
                        end
                    end
                end
                exp_done = nxt_done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        ready_in = 1'b0;
        repeat (3) step();
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", valid_weight_out, 0);
        check("rst_weight_out", weight_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef WEIGHT_LAST_FLAG_EN
        check("rst_weight_last", weight_last, 0);
`endif
        reset = 1'b1;
        step();

        // Full-rate pass with first-word latency checks.
        push_pass();
        pulse_start();
        check("lat_rd_en_first", mem_rd_en, 1);
        check("lat_addr_first", mem_addr, 0);
        check("lat_busy", busy, 1);
        check("lat_valid_early", valid_weight_out, 0);
        step();
        check("lat_valid_early2", valid_weight_out, 0);
        step();
        check("lat_valid_two_cycles", valid_weight_out, 1);
        check("lat_first_word", weight_out, 0);
        wait_idle();

        // Toggling ready.
        rdy_mode = 1;
        push_pass();
        pulse_start();
        wait_idle();
        rdy_mode = 0;
        step();

        // Stall right after the first valid word.
        push_pass();
        pulse_start();
        n = 0;
        while (!valid_weight_out && n < 10) begin
            step();
            n++;
        end
        rdy_mode = 2;
        ready_in = 1'b0;
        reads = 0;
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", valid_weight_out, 1);
            check("stall_hold", weight_out, 0);
            reads += int'(mem_rd_en);
            step();
        end
        check("stall_reads_le_2", reads <= 2, 1);
        ready_in = 1'b1;
        rdy_mode = 0;
        wait_idle();

        // Reset in the middle of a pass.
        push_pass();
        pulse_start();
        n = 0;
        while (!(valid_weight_out && weight_out == 17) && n < 100) begin
            step();
            n++;
        end
        check("reached_word_17", weight_out, 17);
        reset = 1'b0;
        step();
        check("mid_rst_valid", valid_weight_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b1;
        exp_q.delete();
        step();
        push_pass();
        pulse_start();
        wait_idle();

        // Start held high through a pass: a second pass follows directly.
        push_pass();
        push_pass();
        start = 1'b1;
        n = 0;
        while (exp_q.size() > 30 && n < 300) begin
            step();
            n++;
        end
        check("second_pass_started", exp_q.size() <= 30, 1);
        start = 1'b0;
        wait_idle();

        // Start pulses during RUN are ignored.
        push_pass();
        pulse_start();
        repeat (5) step();
        pulse_start();
        repeat (3) step();
        pulse_start();
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            check("no_extra_pass", busy, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
